id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline.
- Sits between the IF/ID latch and the ID/EX boundary, and drives the RegFile read ports (rg_rd_addr1/2, rg_rd_data1/2).
- Decodes the supported MIPS subset, bypasses same-cycle writeback data and detects load-use hazards.
- Registers all results into the ID/EX pipeline register consumed by the execute stage.

---
 rtl/id_stage.sv | 206 ++++++++++++++++++++
 tb/tb_id_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decodes the IF/ID word, bypasses writeback data,
// detects load-use hazards and registers the result into the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_stall,
  input  logic              ex_flush,
  output logic [ADDR_W-1:0] rg_rd_addr1,
  output logic [ADDR_W-1:0] rg_rd_addr2,
  input  logic [DATA_W-1:0] rg_rd_data1,
  input  logic [DATA_W-1:0] rg_rd_data2,
  input  logic              wb_wrt_en,
  input  logic [ADDR_W-1:0] wb_wrt_addr,
  input  logic [DATA_W-1:0] wb_wrt_data,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_dst,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_wrt,
  output logic              ex_mem_rd,
  output logic              ex_mem_wrt,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [25:0]       ex_jaddr,
  output logic              ex_illegal
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    reg_wrt;
    logic    mem_rd;
    logic    mem_wrt;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] dec_dst;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm_ext;
  logic              uses_rt;
  logic              hazard;
  ctrl_t             dec;

  assign opcode = if_instr[31:26];
  assign funct  = if_instr[5:0];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];

  assign rg_rd_addr1 = rs;
  assign rg_rd_addr2 = rt;

  assign imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  // Same-cycle writeback wins over the RegFile read; $0 is hard-wired to zero.
  always_comb begin
    if (rs == '0)                                  rs_data = '0;
    else if (wb_wrt_en && (wb_wrt_addr == rs))     rs_data = wb_wrt_data;
    else                                           rs_data = rg_rd_data1;
    if (rt == '0)                                  rt_data = '0;
    else if (wb_wrt_en && (wb_wrt_addr == rt))     rt_data = wb_wrt_data;
    else                                           rt_data = rg_rd_data2;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    dec     = '0;
    dec_dst = '0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_dst     = rd;
        dec.reg_wrt = 1'b1;
        unique case (funct)
          6'h20:   dec.alu_op = ALU_ADD;
          6'h22:   dec.alu_op = ALU_SUB;
          6'h24:   dec.alu_op = ALU_AND;
          6'h25:   dec.alu_op = ALU_OR;
          6'h2A:   dec.alu_op = ALU_SLT;
          default: begin
            dec.reg_wrt = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_dst     = rt;
        dec.alu_src = 1'b1;
        dec.reg_wrt = 1'b1;
      end
      OP_LW: begin
        dec_dst     = rt;
        dec.alu_src = 1'b1;
        dec.reg_wrt = 1'b1;
        dec.mem_rd  = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 1'b1;
        dec.mem_wrt = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      OP_J:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // addi and lw only read rs; rt is their destination.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign hazard = if_valid && ex_valid && ex_mem_rd && (ex_dst != '0) &&
                  ((ex_dst == rs) || (uses_rt && (ex_dst == rt)));

  assign id_stall = hazard && !ex_flush;

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_jaddr   <= '0;
      ex_alu_op  <= '0;
      ex_alu_src <= 1'b0;
      ex_reg_wrt <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wrt <= 1'b0;
      ex_branch  <= 1'b0;
      ex_jump    <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      ex_pc      <= if_pc;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= imm_ext;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_dst     <= dec_dst;
      ex_jaddr   <= if_instr[25:0];
      if (ex_flush || hazard || !if_valid) begin
        ex_valid   <= 1'b0;
        ex_alu_op  <= '0;
        ex_alu_src <= 1'b0;
        ex_reg_wrt <= 1'b0;
        ex_mem_rd  <= 1'b0;
        ex_mem_wrt <= 1'b0;
        ex_branch  <= 1'b0;
        ex_jump    <= 1'b0;
        ex_illegal <= 1'b0;
      end else begin
        ex_valid   <= 1'b1;
        ex_alu_op  <= dec.alu_op;
        ex_alu_src <= dec.alu_src;
        ex_reg_wrt <= dec.reg_wrt;
        ex_mem_rd  <= dec.mem_rd;
        ex_mem_wrt <= dec.mem_wrt;
        ex_branch  <= dec.branch;
        ex_jump    <= dec.jump;
        ex_illegal <= dec.illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: table of single-instruction decode vectors plus
// hand-written load-use, flush and reset-mid-stall sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        ex_flush;
  logic [4:0]  rg_rd_addr1, rg_rd_addr2;
  logic [31:0] rg_rd_data1, rg_rd_data2;
  logic        wb_wrt_en;
  logic [4:0]  wb_wrt_addr;
  logic [31:0] wb_wrt_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_wrt, ex_mem_rd, ex_mem_wrt, ex_branch, ex_jump;
  logic [25:0] ex_jaddr;
  logic        ex_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_stall(id_stall), .ex_flush(ex_flush),
    .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
    .rg_rd_data1(rg_rd_data1), .rg_rd_data2(rg_rd_data2),
    .wb_wrt_en(wb_wrt_en), .wb_wrt_addr(wb_wrt_addr), .wb_wrt_data(wb_wrt_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_wrt(ex_reg_wrt),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wrt(ex_mem_wrt), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jaddr(ex_jaddr), .ex_illegal(ex_illegal)
  );

  // ctl packs {alu_src, reg_wrt, mem_rd, mem_wrt, branch, jump, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        chk_dst;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        chk_alu;
    logic [2:0]  alu_op;
    logic [6:0]  ctl;
    logic [25:0] jaddr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ex_all();
    return {ex_valid, ex_alu_op, ex_alu_src, ex_reg_wrt, ex_mem_rd, ex_mem_wrt,
            ex_branch, ex_jump, ex_illegal, ex_dst, ex_rs, ex_rt} |
           ex_pc | ex_rs_data | ex_rt_data | ex_imm | {6'd0, ex_jaddr};
  endfunction

  initial begin
    //         instr         rd1           rd2           wb  waddr  wdata         cd dst    imm           rs_data       rt_data       ca alu   ctl          jaddr
    vecs[0]  = '{32'h20080045, 32'h00001234, 32'h00000022, 0, 5'd0,  32'h0,        1, 5'd8,  32'h00000045, 32'h00000000, 32'h00000022, 1, 3'd0, 7'b1100000, 26'h0};
    vecs[1]  = '{32'h2009FFFF, 32'h00000005, 32'h00000006, 0, 5'd0,  32'h0,        1, 5'd9,  32'hFFFFFFFF, 32'h00000000, 32'h00000006, 1, 3'd0, 7'b1100000, 26'h0};
    vecs[2]  = '{32'h03001020, 32'h00000000, 32'h00000099, 1, 5'd24, 32'h00000045, 1, 5'd2,  32'h00001020, 32'h00000045, 32'h00000000, 1, 3'd0, 7'b0100000, 26'h0};
    vecs[3]  = '{32'h03001020, 32'h00000000, 32'h00000099, 1, 5'd0,  32'h00000045, 1, 5'd2,  32'h00001020, 32'h00000000, 32'h00000000, 1, 3'd0, 7'b0100000, 26'h0};
    vecs[4]  = '{32'h03001020, 32'h00000077, 32'h00000099, 1, 5'd23, 32'h00000045, 1, 5'd2,  32'h00001020, 32'h00000077, 32'h00000000, 1, 3'd0, 7'b0100000, 26'h0};
    vecs[5]  = '{32'h00851822, 32'h00000010, 32'h00000020, 1, 5'd5,  32'h000000AB, 1, 5'd3,  32'h00001822, 32'h00000010, 32'h000000AB, 1, 3'd1, 7'b0100000, 26'h0};
    vecs[6]  = '{32'h00223824, 32'h0000F0F0, 32'h00000FF0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h00003824, 32'h0000F0F0, 32'h00000FF0, 1, 3'd2, 7'b0100000, 26'h0};
    vecs[7]  = '{32'h00223825, 32'h0000F0F0, 32'h00000FF0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h00003825, 32'h0000F0F0, 32'h00000FF0, 1, 3'd3, 7'b0100000, 26'h0};
    vecs[8]  = '{32'h0022382A, 32'h0000F0F0, 32'h00000FF0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h0000382A, 32'h0000F0F0, 32'h00000FF0, 1, 3'd4, 7'b0100000, 26'h0};
    vecs[9]  = '{32'h8C250000, 32'h00001000, 32'h00000033, 0, 5'd0,  32'h0,        1, 5'd5,  32'h00000000, 32'h00001000, 32'h00000033, 1, 3'd0, 7'b1110000, 26'h0};
    vecs[10] = '{32'hAC250004, 32'h00001000, 32'h00005555, 1, 5'd1,  32'h0000DEAD, 0, 5'd0,  32'h00000004, 32'h0000DEAD, 32'h00005555, 1, 3'd0, 7'b1001000, 26'h0};
    vecs[11] = '{32'h1022FFFF, 32'h00000001, 32'h00000001, 0, 5'd0,  32'h0,        0, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 3'd1, 7'b0000100, 26'h0};
    vecs[12] = '{32'h08123456, 32'h00000011, 32'h00000044, 0, 5'd0,  32'h0,        0, 5'd0,  32'h00003456, 32'h00000000, 32'h00000044, 0, 3'd0, 7'b0000010, 26'h123456};
    vecs[13] = '{32'h0000003F, 32'h00000011, 32'h00000022, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0000003F, 32'h00000000, 32'h00000000, 0, 3'd0, 7'b0000001, 26'h0};
    vecs[14] = '{32'hFC000000, 32'h00000011, 32'h00000022, 0, 5'd0,  32'h0,        0, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 0, 3'd0, 7'b0000001, 26'h0};

    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h00A53020; if_pc = 32'h40;
    ex_flush = 1'b0; rg_rd_data1 = 32'h5; rg_rd_data2 = 32'h6;
    wb_wrt_en = 1'b0; wb_wrt_addr = '0; wb_wrt_data = '0;

    // Reset held for 100 ns with a valid instruction presented
    #1;
    check("rst_ex_early", ex_all(), 32'h0);
    check("rst_stall_early", {31'd0, id_stall}, 32'h0);
    check("rst_rd_addr1", {27'd0, rg_rd_addr1}, 32'd5);
    #98;
    check("rst_ex_late", ex_all(), 32'h0);
    check("rst_stall_late", {31'd0, id_stall}, 32'h0);
    #1 rst = 1'b0; if_valid = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, ex_valid}, 32'h0);

    foreach (vecs[i]) begin
      if_instr    = vecs[i].instr;
      if_pc       = 32'h100 + 32'(i) * 4;
      rg_rd_data1 = vecs[i].rd1;
      rg_rd_data2 = vecs[i].rd2;
      wb_wrt_en   = vecs[i].wb_en;
      wb_wrt_addr = vecs[i].wb_addr;
      wb_wrt_data = vecs[i].wb_data;
      if_valid    = 1'b1;
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      check($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(i) * 4);
      check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      check($sformatf("v%0d_rs_data", i), ex_rs_data, vecs[i].rs_data);
      check($sformatf("v%0d_rt_data", i), ex_rt_data, vecs[i].rt_data);
      check($sformatf("v%0d_ctl", i),
            {25'd0, ex_alu_src, ex_reg_wrt, ex_mem_rd, ex_mem_wrt, ex_branch, ex_jump, ex_illegal},
            {25'd0, vecs[i].ctl});
      if (vecs[i].chk_dst) check($sformatf("v%0d_dst", i), {27'd0, ex_dst}, {27'd0, vecs[i].dst});
      if (vecs[i].chk_alu) check($sformatf("v%0d_alu", i), {29'd0, ex_alu_op}, {29'd0, vecs[i].alu_op});
      if (vecs[i].ctl[1])  check($sformatf("v%0d_jaddr", i), {6'd0, ex_jaddr}, {6'd0, vecs[i].jaddr});
      if_valid = 1'b0;
      tick();
      check($sformatf("v%0d_idle_valid", i), {31'd0, ex_valid}, 32'h0);
      check($sformatf("v%0d_idle_ctl", i),
            {25'd0, ex_alu_src, ex_reg_wrt, ex_mem_rd, ex_mem_wrt, ex_branch, ex_jump, ex_illegal}, 32'h0);
    end
    wb_wrt_en = 1'b0;

    // Load-use: lw $5,0($1) then add $6,$5,$5
    if_instr = 32'h8C250000; if_valid = 1'b1;
    tick();
    check("lu_lw_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    if_instr = 32'h00A53020;
    #1;
    check("lu_stall", {31'd0, id_stall}, 32'd1);
    check("lu_rd_addr1", {27'd0, rg_rd_addr1}, 32'd5);
    check("lu_rd_addr2", {27'd0, rg_rd_addr2}, 32'd5);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_wrt", {31'd0, ex_reg_wrt}, 32'd0);
    check("lu_stall_clear", {31'd0, id_stall}, 32'd0);
    tick();
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_add_rs", {27'd0, ex_rs}, 32'd5);
    check("lu_add_dst", {27'd0, ex_dst}, 32'd6);
    check("lu_add_wrt", {31'd0, ex_reg_wrt}, 32'd1);
    if_valid = 1'b0;
    tick();

    // rt-only dependency stalls sw but not addi; flush overrides the hazard
    if_instr = 32'h8C250000; if_valid = 1'b1;
    tick();
    if_instr = 32'hAC450000;
    #1 check("sw_rt_stall", {31'd0, id_stall}, 32'd1);
    if_instr = 32'h20050001;
    #1 check("addi_rt_nostall", {31'd0, id_stall}, 32'd0);
    if_instr = 32'h00A53020; if_valid = 1'b0;
    #1 check("invalid_nostall", {31'd0, id_stall}, 32'd0);
    if_valid = 1'b1; ex_flush = 1'b1;
    #1 check("flush_nostall", {31'd0, id_stall}, 32'd0);
    tick();
    check("flush_bubble", {31'd0, ex_valid}, 32'd0);
    check("flush_bubble_wrt", {31'd0, ex_reg_wrt}, 32'd0);
    ex_flush = 1'b0; if_valid = 1'b0;
    tick();
    check("flush_dropped", {31'd0, ex_valid}, 32'd0);

    // Load to $0 never creates a hazard
    if_instr = 32'h8C200000; if_valid = 1'b1;
    tick();
    if_instr = 32'h00003020;
    #1 check("lw_r0_nostall", {31'd0, id_stall}, 32'd0);

    // Reset asserted in the middle of a stall
    if_valid = 1'b0;
    tick();
    if_instr = 32'h8C250000; if_valid = 1'b1;
    tick();
    if_instr = 32'h00A53020;
    #1 check("mid_stall_set", {31'd0, id_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, id_stall}, 32'd0);
    check("mid_rst_ex", ex_all(), 32'h0);
    rst = 1'b0; if_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
